// File: rtl/rr_grant_keeper.sv
// rr_grant_keeper
//   Sequential wrapper around a rotate-priority (round-robin) arbiter for one
//   router output port. It remembers the last winner (ptr) and searches from
//   ptr+1 upward. It also holds the grant on a single input port from the head
//   flit to the tail flit of a wormhole packet.
//
//   Handshake: a flit crosses on every cycle where grant_valid is 1.
//   grant_valid already includes out_ready, so xfer = grant_valid & out_ready
//   is the same as grant_valid. The grant is combinational, so the grant and
//   the transfer happen in the same cycle.
//
// Ports
//   clk          router clock; all state updates on the rising edge
//   reset_n      asynchronous, active-low reset
//   req          per-port "has a valid flit for this output"
//   req_tail     per-port "presented flit is a tail / single-flit packet"
//   out_ready    downstream credit available this cycle
//   grant_valid  a flit transfers this cycle
//   grant_idx    binary index of the granted port (0 when grant_valid=0)
//   grant_oh     one-hot of grant_idx, gated by grant_valid
//   locked       the FSM is in LOCK (a packet owns the output)
//   lock_err     sticky: a packet reached MAX_FLITS without a tail
module rr_grant_keeper #(
    parameter int P_NUM     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_FLITS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [P_NUM-1:0] req,
    input  logic [P_NUM-1:0] req_tail,
    input  logic             out_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [P_NUM-1:0] grant_oh,
    output logic             locked,
    output logic             lock_err
);

    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   owner, owner_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   flit_cnt, cnt_nx;
    logic               err_nx;

    // Arbiter search signals
    logic               arb_found;
    logic [IDX_W-1:0]   arb_win;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    // Rotate-priority search: the first requester at ptr+1, ptr+2, ...,
    // wrapping modulo P_NUM, wins. The last slot checked is ptr itself,
    // so the previous winner has the lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= P_NUM; k++) begin
            cand = int'(ptr) + k;
            if (cand >= P_NUM) begin
                cand = cand - P_NUM;
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_win   = cand_idx;
            end
        end
    end

    // Next-state and grant logic
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        ptr_nx      = ptr;
        cnt_nx      = flit_cnt;
        err_nx      = lock_err;
        grant_valid = 1'b0;
        grant_idx   = '0;

        unique case (state)
            ST_IDLE: begin
                grant_valid = arb_found & out_ready;
                if (grant_valid) begin
                    grant_idx = arb_win;
                    if (req_tail[arb_win]) begin
                        // Single-flit packet: rotate priority, stay idle.
                        ptr_nx = arb_win;
                    end else begin
                        state_nx = ST_LOCK;
                        owner_nx = arb_win;
                        cnt_nx   = CNT_W'(1);
                        if (MAX_FLITS == 1) begin
                            err_nx = 1'b1;
                        end
                    end
                end
            end
            ST_LOCK: begin
                // Only the owner is considered. Other ports wait, even if
                // they have higher priority.
                grant_valid = req[owner] & out_ready;
                if (grant_valid) begin
                    grant_idx = owner;
                    if (req_tail[owner]) begin
                        state_nx = ST_IDLE;
                        ptr_nx   = owner;
                        cnt_nx   = '0;
                    end else begin
                        if (flit_cnt != CNT_W'(MAX_FLITS)) begin
                            cnt_nx = flit_cnt + CNT_W'(1);
                        end
                        // The watchdog only reports. The lock is kept
                        // until the tail arrives.
                        if (flit_cnt == CNT_W'(MAX_FLITS - 1)) begin
                            err_nx = 1'b1;
                        end
                    end
                end
            end
        endcase

        // The state is already reset here, but req is live, so the
        // combinational grant must be masked while reset is held.
        if (!reset_n) begin
            grant_valid = 1'b0;
            grant_idx   = '0;
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign locked = (state == ST_LOCK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= IDX_W'(P_NUM - 1);
            flit_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            ptr      <= ptr_nx;
            flit_cnt <= cnt_nx;
            lock_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_rr_grant_keeper.sv
// Bench for rr_grant_keeper.
//   dut_a : P_NUM=4, MAX_FLITS=16
//   dut_b : P_NUM=4, MAX_FLITS=4   (same inputs as dut_a)
//   dut_c : P_NUM=2, IDX_W=1
// The reference model describes packets and priority order, not registers.
// It advances once per rising edge that the driver passes. A negedge
// process compares every output of every instance with the model.
module tb_rr_grant_keeper;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- stimulus / DUT wiring ----------------
    logic [3:0] req4, tail4;
    logic       rdy4;
    logic [1:0] req2, tail2;
    logic       rdy2;

    logic       a_gv, a_lk, a_le;
    logic [1:0] a_gi;
    logic [3:0] a_go;
    logic       b_gv, b_lk, b_le;
    logic [1:0] b_gi;
    logic [3:0] b_go;
    logic       c_gv, c_lk, c_le;
    logic [0:0] c_gi;
    logic [1:0] c_go;

    rr_grant_keeper #(.P_NUM(4), .IDX_W(2), .MAX_FLITS(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req4), .req_tail(tail4), .out_ready(rdy4),
        .grant_valid(a_gv), .grant_idx(a_gi), .grant_oh(a_go), .locked(a_lk), .lock_err(a_le)
    );
    rr_grant_keeper #(.P_NUM(4), .IDX_W(2), .MAX_FLITS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req4), .req_tail(tail4), .out_ready(rdy4),
        .grant_valid(b_gv), .grant_idx(b_gi), .grant_oh(b_go), .locked(b_lk), .lock_err(b_le)
    );
    rr_grant_keeper #(.P_NUM(2), .IDX_W(1), .MAX_FLITS(16)) dut_c (
        .clk(clk), .reset_n(reset_n), .req(req2), .req_tail(tail2), .out_ready(rdy2),
        .grant_valid(c_gv), .grant_idx(c_gi), .grant_oh(c_go), .locked(c_lk), .lock_err(c_le)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model 0 serves dut_a and dut_b. Model 1 serves dut_c.
    // m_len is the flit count of the open packet and is not saturated.
    // m_err is kept per instance, because each instance has its own MAX_FLITS.
    int m_p[2]   = '{4, 2};
    int m_max[3] = '{16, 4, 16};
    int m_ptr[2], m_owner[2], m_len[2];
    bit m_lock[2];
    bit m_err[3];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]   = m_p[m] - 1;
            m_owner[m] = 0;
            m_len[m]   = 0;
            m_lock[m]  = 1'b0;
        end
        for (int k = 0; k < 3; k++) m_err[k] = 1'b0;
    endfunction

    // Who gets the output this cycle. Under a lock, only the owner can be
    // granted. Otherwise the first requester after the last winner wins.
    function automatic void model_grant(input int m, input logic [3:0] r, input logic rdy,
                                        output bit v, output int idx);
        v   = 1'b0;
        idx = 0;
        if (!rdy) return;
        if (m_lock[m]) begin
            if (r[m_owner[m]]) begin
                v   = 1'b1;
                idx = m_owner[m];
            end
        end else begin
            for (int k = 1; k <= m_p[m]; k++) begin
                int c;
                c = (m_ptr[m] + k) % m_p[m];
                if (!v && r[c]) begin
                    v   = 1'b1;
                    idx = c;
                end
            end
        end
    endfunction

    function automatic void model_len_err(input int m);
        if (m == 0) begin
            if (m_len[0] >= m_max[0]) m_err[0] = 1'b1;
            if (m_len[0] >= m_max[1]) m_err[1] = 1'b1;
        end else begin
            if (m_len[1] >= m_max[2]) m_err[2] = 1'b1;
        end
    endfunction

    function automatic void model_step(input int m, input logic [3:0] r, input logic [3:0] t,
                                       input logic rdy);
        bit v;
        int idx;
        model_grant(m, r, rdy, v, idx);
        if (!v) return;
        if (t[idx]) begin
            // A packet ends, either a tail or a single-flit packet.
            m_lock[m] = 1'b0;
            m_ptr[m]  = idx;
            m_len[m]  = 0;
        end else if (m_lock[m]) begin
            m_len[m]++;
            model_len_err(m);
        end else begin
            m_lock[m]  = 1'b1;
            m_owner[m] = idx;
            m_len[m]   = 1;
            model_len_err(m);
        end
    endfunction

    function automatic logic [31:0] pack(input logic gv, input logic [1:0] gi, input logic [3:0] go,
                                         input logic lk, input logic le);
        return {23'b0, gv, gi, go, lk, le};
    endfunction

    function automatic logic [31:0] exp_vec(input int k, input logic [3:0] r, input logic rdy);
        bit v;
        int idx;
        int m;
        logic [3:0] oh;
        if (!reset_n) return 32'h0;
        m = (k == 2) ? 1 : 0;
        model_grant(m, r, rdy, v, idx);
        oh = v ? 4'(1 << idx) : 4'h0;
        return pack(v, 2'(idx), oh, m_lock[m], m_err[k]);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_outs", pack(a_gv, a_gi, a_go, a_lk, a_le), exp_vec(0, req4, rdy4));
            chk("b_outs", pack(b_gv, b_gi, b_go, b_lk, b_le), exp_vec(1, req4, rdy4));
            chk("c_outs", pack(c_gv, {1'b0, c_gi}, {2'b00, c_go}, c_lk, c_le),
                exp_vec(2, {2'b00, req2}, rdy2));
        end
    end

    // ---------------- driver tasks ----------------
    // The driver is called just after a rising edge. It applies inputs and
    // returns at the falling edge, where the caller may check literals.
    task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic rd);
        req4  = r;
        tail4 = t;
        rdy4  = rd;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_n) begin
            model_step(0, req4, tail4, rdy4);
            model_step(1, {2'b00, req2}, {2'b00, tail2}, rdy2);
        end
        #1;
    endtask

    // Assert reset in the middle of a cycle and release it just after the
    // next rising edge.
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0;
        req4 = 4'hf; tail4 = 4'hf; rdy4 = 1'b1;
        req2 = 2'b11; tail2 = 2'b11; rdy2 = 1'b1;
        model_reset();
        cmp_en = 1'b1;

        // Reset held while requests are active: all outputs must be quiet.
        #2;
        chk("rst_gv",   a_gv, 0);
        chk("rst_oh",   a_go, 0);
        chk("rst_lk",   a_lk, 0);
        chk("rst_le",   a_le, 0);
        chk("rst_c_oh", c_go, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1 & 6: all ports request single-flit packets. The 4-port instances
        // rotate 0..3; the 2-port instance alternates 0,1.
        for (int i = 0; i < 8; i++) begin
            drive(4'hf, 4'hf, 1'b1);
            chk("t1_idx", a_gi, i % 4);
            chk("t1_lk",  a_lk, 0);
            if (i < 4) begin
                chk("t6_idx", c_gi, i % 2);
                chk("t6_oh",  c_go, (i % 2 == 0) ? 1 : 2);
            end
            advance();
        end
        req2 = 2'b00; tail2 = 2'b00;

        // 2: 3-flit packet on port 2. Ports 0 and 1 join but must wait.
        drive(4'b0100, 4'b0000, 1'b1);
        chk("t2_head", a_gi, 2);
        advance();
        drive(4'b0111, 4'b0000, 1'b1);
        chk("t2_mid", a_gi, 2);
        chk("t2_lk",  a_lk, 1);
        advance();
        drive(4'b0111, 4'b0100, 1'b1);
        chk("t2_tail", a_gi, 2);
        chk("t2_lk2",  a_lk, 1);
        advance();
        drive(4'b0011, 4'b0011, 1'b1);
        chk("t2_next0", a_gi, 0);
        chk("t2_unlk",  a_lk, 0);
        advance();
        drive(4'b0011, 4'b0011, 1'b1);
        chk("t2_next1", a_gi, 1);
        advance();

        // 3: packet on port 3 stalled by 2 cycles without credit and 1 bubble.
        drive(4'b1000, 4'b0000, 1'b1);
        chk("t3_head", a_gi, 3);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            chk("t3_nocred", a_gv, 0);
            chk("t3_lk",     a_lk, 1);
            advance();
        end
        drive(4'b0111, 4'b0111, 1'b1);
        chk("t3_bubble", a_gv, 0);
        advance();
        drive(4'b1111, 4'b1000, 1'b1);
        chk("t3_tail", {a_gv, a_gi}, 3'b111);
        advance();

        // 4: 6-flit packet on port 1. dut_b (MAX_FLITS=4) flags the 4th flit.
        drive(4'b0010, 4'b0000, 1'b1);
        chk("t4_head", a_gi, 1);
        advance();
        for (int f = 2; f <= 5; f++) begin
            drive(4'b1011, 4'b1101, 1'b1);
            chk("t4_body", b_gi, 1);
            chk("t4_err",  b_le, (f >= 5) ? 1 : 0);
            advance();
        end
        drive(4'b0011, 4'b0010, 1'b1);
        chk("t4_tail", b_gi, 1);
        chk("t4_err6", b_le, 1);
        advance();
        drive(4'b1111, 4'b1111, 1'b1);
        chk("t4_next", b_gi, 2);
        chk("t4_unlk", b_lk, 0);
        chk("t4_errk", b_le, 1);
        chk("t4_aerr", a_le, 0);
        advance();

        // 5: asynchronous reset while port 3 holds the lock.
        drive(4'b1000, 4'b0000, 1'b1);
        chk("t5_head", a_gi, 3);
        advance();
        req4 = 4'b1000; tail4 = 4'b0000; rdy4 = 1'b1;
        #1;
        chk("t5_pre", {a_gv, a_lk}, 2'b11);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5_gv", a_gv, 0);
        chk("t5_oh", a_go, 0);
        chk("t5_lk", a_lk, 0);
        chk("t5_le", b_le, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(4'b1001, 4'b1001, 1'b1);
        chk("t5_first", a_gi, 0);
        advance();
        drive(4'b1001, 4'b1001, 1'b1);
        chk("t5_second", a_gi, 3);
        advance();

        // Random traffic on all instances, with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r, t;
            r = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) t[b] = ($urandom_range(0, 2) == 0);
            req2  = 2'($urandom_range(0, 3));
            tail2 = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            rdy2  = ($urandom_range(0, 3) != 0);
            drive(r, t, $urandom_range(0, 3) != 0);
            advance();
            if (n == 1500) pulse_reset();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
